// File: rtl/register_bank_dual_wb_if.sv
// Bus bundle for register_bank_dual_wb: two writeback ports, lock/scoreboard and two read ports.
// The control unit holds the master side and the register bank holds the slave side.
interface register_bank_dual_wb_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_REGS = 16
);
  logic              i_we_a;
  logic [ADDR_W-1:0] i_dest_a;
  logic [DATA_W-1:0] i_load_a;
  logic              i_we_b;
  logic [ADDR_W-1:0] i_dest_b;
  logic [DATA_W-1:0] i_load_b;
  logic              i_lock;
  logic [ADDR_W-1:0] i_lock_dest;
  logic [ADDR_W-1:0] i_R1;
  logic [ADDR_W-1:0] i_R2;
  logic [DATA_W-1:0] o_R1;
  logic [DATA_W-1:0] o_R2;
  logic              o_busy1;
  logic              o_busy2;
  logic [NUM_REGS-1:0] o_pending;

  modport master (
    output i_we_a, i_dest_a, i_load_a, i_we_b, i_dest_b, i_load_b,
    output i_lock, i_lock_dest, i_R1, i_R2,
    input  o_R1, o_R2, o_busy1, o_busy2, o_pending
  );

  modport slave (
    input  i_we_a, i_dest_a, i_load_a, i_we_b, i_dest_b, i_load_b,
    input  i_lock, i_lock_dest, i_R1, i_R2,
    output o_R1, o_R2, o_busy1, o_busy2, o_pending
  );
endinterface

// File: rtl/register_bank_dual_wb.sv
// Dual-writeback register bank with a pending-load scoreboard and two combinational read ports.
// Define REGBANK_BYPASS_EN to forward same-cycle write data and load-return clears to the reads.
module register_bank_dual_wb #(
  parameter int unsigned    DATA_W    = 32,
  parameter int unsigned    ADDR_W    = 4,
  parameter int unsigned    NUM_REGS  = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic Clk,
  input logic Rst,
  register_bank_dual_wb_if.slave bus
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // Out-of-range addresses never match any index, so they fall out of every loop below.
  always_comb begin
    pending_d = pending_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (bus.i_we_b && bus.i_dest_b == ADDR_W'(r)) pending_d[r] = 1'b0;
      if (bus.i_lock && bus.i_lock_dest == ADDR_W'(r)) pending_d[r] = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= RESET_VAL;
      pending_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (bus.i_we_a && bus.i_dest_a == ADDR_W'(r)) begin
          regs_q[r] <= bus.i_load_a;
        end else if (bus.i_we_b && bus.i_dest_b == ADDR_W'(r)) begin
          regs_q[r] <= bus.i_load_b;
        end
      end
      pending_q <= pending_d;
    end
  end

  logic [DATA_W-1:0] rd1, rd2;
  logic              busy1, busy2;
  logic              hit1, hit2;

  always_comb begin
    rd1   = '0;
    rd2   = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    hit1  = 1'b0;
    hit2  = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (bus.i_R1 == ADDR_W'(r)) begin
        rd1   = regs_q[r];
        busy1 = pending_q[r];
        hit1  = 1'b1;
      end
      if (bus.i_R2 == ADDR_W'(r)) begin
        rd2   = regs_q[r];
        busy2 = pending_q[r];
        hit2  = 1'b1;
      end
    end
`ifdef REGBANK_BYPASS_EN
    if (!Rst) begin
      // Port B first so that port A overrides it on a shared destination.
      if (hit1 && bus.i_we_b && bus.i_dest_b == bus.i_R1) begin
        rd1   = bus.i_load_b;
        busy1 = 1'b0;
      end
      if (hit1 && bus.i_we_a && bus.i_dest_a == bus.i_R1) rd1 = bus.i_load_a;
      if (hit2 && bus.i_we_b && bus.i_dest_b == bus.i_R2) begin
        rd2   = bus.i_load_b;
        busy2 = 1'b0;
      end
      if (hit2 && bus.i_we_a && bus.i_dest_a == bus.i_R2) rd2 = bus.i_load_a;
    end
`else
    hit1 = hit1;
    hit2 = hit2;
`endif
  end

  assign bus.o_R1      = rd1;
  assign bus.o_R2      = rd2;
  assign bus.o_busy1   = busy1;
  assign bus.o_busy2   = busy2;
  assign bus.o_pending = pending_q;

endmodule

// File: tb/tb_register_bank_dual_wb.sv
// Directed bench for register_bank_dual_wb built with NUM_REGS=12 so that addresses 12..15
// are out of range; same-cycle expectations follow REGBANK_BYPASS_EN.
module tb_register_bank_dual_wb;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned NR = 12;

  logic Clk = 1'b0;
  logic Rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 Clk = ~Clk;

  register_bank_dual_wb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) bus ();

  register_bank_dual_wb #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_REGS (NR),
    .RESET_VAL('0)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.i_we_a = 1'b0;
    bus.i_we_b = 1'b0;
    bus.i_lock = 1'b0;
  endtask

  initial begin
    Rst             = 1'b1;
    bus.i_we_a      = 1'b1;
    bus.i_dest_a    = 4'd3;
    bus.i_load_a    = 32'hDEAD;
    bus.i_we_b      = 1'b0;
    bus.i_dest_b    = '0;
    bus.i_load_b    = '0;
    bus.i_lock      = 1'b1;
    bus.i_lock_dest = 4'd3;
    bus.i_R1        = '0;
    bus.i_R2        = '0;
    @(negedge Clk);
    tick();
    Rst = 1'b0;
    idle();
    #1;

    // Reset: every register reads 0, nothing pending, write/lock in reset cycle ignored
    for (int i = 0; i < 16; i++) begin
      bus.i_R1 = AW'(i);
      #1;
      chk($sformatf("reset_r1_%0d", i), bus.o_R1, 32'h0);
    end
    chk("reset_pending", {20'h0, bus.o_pending}, 32'h0);
    chk("reset_busy1", {31'h0, bus.o_busy1}, 32'h0);

    // Port A write, visible same cycle only with bypass
    bus.i_we_a = 1'b1; bus.i_dest_a = 4'd5; bus.i_load_a = 32'h1234_5678;
    bus.i_R1 = 4'd5; bus.i_R2 = 4'd5;
    #1;
`ifdef REGBANK_BYPASS_EN
    chk("wr_same_r1", bus.o_R1, 32'h1234_5678);
    chk("wr_same_r2", bus.o_R2, 32'h1234_5678);
`else
    chk("wr_same_r1", bus.o_R1, 32'h0);
    chk("wr_same_r2", bus.o_R2, 32'h0);
`endif
    tick(); idle(); #1;
    chk("wr_next_r1", bus.o_R1, 32'h1234_5678);
    chk("wr_next_r2", bus.o_R2, 32'h1234_5678);

    // Collision on R7: A wins
    bus.i_we_a = 1'b1; bus.i_dest_a = 4'd7; bus.i_load_a = 32'hAAAA_AAAA;
    bus.i_we_b = 1'b1; bus.i_dest_b = 4'd7; bus.i_load_b = 32'hBBBB_BBBB;
    bus.i_R1 = 4'd7;
    tick(); idle(); #1;
    chk("collision_r7", bus.o_R1, 32'hAAAA_AAAA);

    // Port B alone to R8
    bus.i_we_b = 1'b1; bus.i_dest_b = 4'd8; bus.i_load_b = 32'h8888_0008;
    bus.i_R2 = 4'd8;
    tick(); idle(); #1;
    chk("portb_r8", bus.o_R2, 32'h8888_0008);

    // Lock R2: pending and busy until a port B write
    bus.i_lock = 1'b1; bus.i_lock_dest = 4'd2; bus.i_R1 = 4'd2;
    tick(); idle(); #1;
    chk("lock_pending", {20'h0, bus.o_pending}, 32'h0000_0004);
    chk("lock_busy1", {31'h0, bus.o_busy1}, 32'h1);
    tick(); #1;
    chk("lock_hold_busy1", {31'h0, bus.o_busy1}, 32'h1);

    // Same-cycle lock and clear of R2: set wins, data still written
    bus.i_lock = 1'b1; bus.i_lock_dest = 4'd2;
    bus.i_we_b = 1'b1; bus.i_dest_b = 4'd2; bus.i_load_b = 32'h0000_0011;
    tick(); idle(); #1;
    chk("lockclr_pending", {20'h0, bus.o_pending}, 32'h0000_0004);
    chk("lockclr_busy1", {31'h0, bus.o_busy1}, 32'h1);
    chk("lockclr_r2", bus.o_R1, 32'h0000_0011);

    // Load return to R2
    bus.i_we_b = 1'b1; bus.i_dest_b = 4'd2; bus.i_load_b = 32'h0000_0022;
    #1;
`ifdef REGBANK_BYPASS_EN
    chk("ret_same_busy1", {31'h0, bus.o_busy1}, 32'h0);
    chk("ret_same_r1", bus.o_R1, 32'h0000_0022);
`else
    chk("ret_same_busy1", {31'h0, bus.o_busy1}, 32'h1);
    chk("ret_same_r1", bus.o_R1, 32'h0000_0011);
`endif
    tick(); idle(); #1;
    chk("ret_pending", {20'h0, bus.o_pending}, 32'h0);
    chk("ret_busy1", {31'h0, bus.o_busy1}, 32'h0);
    chk("ret_r1", bus.o_R1, 32'h0000_0022);

    // Port A write to a locked register leaves it pending
    bus.i_lock = 1'b1; bus.i_lock_dest = 4'd3;
    tick(); idle();
    bus.i_we_a = 1'b1; bus.i_dest_a = 4'd3; bus.i_load_a = 32'h0000_0033;
    tick(); idle();
    bus.i_R1 = 4'd3; #1;
    chk("porta_pending", {20'h0, bus.o_pending}, 32'h0000_0008);
    chk("porta_busy1", {31'h0, bus.o_busy1}, 32'h1);
    chk("porta_r3", bus.o_R1, 32'h0000_0033);

    // Mid-load reset on R9, then late load return accepted
    bus.i_lock = 1'b1; bus.i_lock_dest = 4'd9; bus.i_R2 = 4'd9;
    tick(); idle(); #1;
    chk("midload_busy2", {31'h0, bus.o_busy2}, 32'h1);
    Rst = 1'b1;
    tick(); Rst = 1'b0; #1;
    chk("midload_rst_pending", {20'h0, bus.o_pending}, 32'h0);
    chk("midload_rst_busy2", {31'h0, bus.o_busy2}, 32'h0);
    chk("midload_rst_r3", bus.o_R1, 32'h0);
    bus.i_we_b = 1'b1; bus.i_dest_b = 4'd9; bus.i_load_b = 32'h0F0F_0F0F;
    tick(); idle(); #1;
    chk("midload_r9", bus.o_R2, 32'h0F0F_0F0F);
    chk("midload_pending", {20'h0, bus.o_pending}, 32'h0);

    // Out-of-range writes and locks are ignored; reads return 0, not busy
    bus.i_we_a = 1'b1; bus.i_dest_a = 4'd13; bus.i_load_a = 32'h5555_5555;
    bus.i_we_b = 1'b1; bus.i_dest_b = 4'd12; bus.i_load_b = 32'h6666_6666;
    bus.i_lock = 1'b1; bus.i_lock_dest = 4'd14;
    bus.i_R1 = 4'd13; bus.i_R2 = 4'd12;
    #1;
    chk("range_same_r1", bus.o_R1, 32'h0);
    chk("range_same_r2", bus.o_R2, 32'h0);
    tick(); idle(); #1;
    chk("range_r13", bus.o_R1, 32'h0);
    chk("range_r12", bus.o_R2, 32'h0);
    chk("range_pending", {20'h0, bus.o_pending}, 32'h0);
    bus.i_R1 = 4'd14; #1;
    chk("range_busy14", {31'h0, bus.o_busy1}, 32'h0);
    bus.i_R1 = 4'd9; #1;
    chk("range_r9_kept", bus.o_R1, 32'h0F0F_0F0F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
